window_addr_gen: RTL and testbench
==================================

# window_addr_gen

Parametrised address sequencer for the convolution accelerator's memory control path. It emits the address stream for a KxK window of an image stored row-major in memory: scope mode, with run-time kernel size and row pitch. It also emits a persistent, auto-advancing kernel-weight pointer stream: kernel mode. Output is one address per beat under a valid/ready handshake, so the memory read port can stall the sequence.

## Interface
- ADDR_W, 14, address width; all address arithmetic is modulo 2^ADDR_W
- KSZ_W, 3, width of the ksize input
- KMAX, 7, largest legal kernel dimension; must be <= 2^KSZ_W - 1
- KERNEL_BASE, 0, reset/clear value of the kernel pointer

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  00 NOOP, 01 LOAD SCOPE, 10 LOAD KERNEL, 11 reserved
- base  in  ADDR_W  scope mode: address of the window's top-left element
- pitch  in  ADDR_W  scope mode: image row width in elements
- ksize  in  KSZ_W  kernel dimension K; the burst length is K*K
- kclr  in  1  reloads the kernel pointer with KERNEL_BASE; honoured only in IDLE
- ready  in  1  downstream accepts the current address
- addr  out  ADDR_W  current address; this is a pointer, not data
- addr_valid  out  1  addr is meaningful
- last  out  1  marks the final address of the burst; qualified by addr_valid
- busy  out  1  a burst is in progress
- done  out  1  one-cycle pulse after the final beat is accepted
- err  out  1  one-cycle pulse when a start request is rejected

## Operation
- States: IDLE, SCOPE, KERN, DONE.
- **IDLE, start=1, mode=01, 1<=ksize<=KMAX:**
  - Latch base, pitch and ksize.
  - Set row_base=base, col=0, row=0.
  - Go to SCOPE.
- **IDLE, start=1, mode=10, legal ksize:**
  - Latch ksize.
  - Set cnt=0.
  - Go to KERN.
- **IDLE, start=1, rejected request:** covers mode=11, or ksize=0, or ksize>KMAX.
  - Pulse err.
  - Stay in IDLE; no other state changes.
- **IDLE, start=1, mode=00:** ignored; no err.
- **SCOPE:**
  - addr = row_base + col.
  - On each accepted beat: if col==K-1, then col=0, row+=1 and row_base+=pitch; otherwise col+=1.
  - After row K-1, col K-1 is accepted, go to DONE.
  - No multiplier; the sequence is strictly incremental.
- **KERN:**
  - addr = kptr.
  - Each accepted beat increments kptr and cnt.
  - After K*K beats, go to DONE.
  - kptr persists across bursts, so consecutive kernel bursts are contiguous.
  - kptr wraps modulo 2^ADDR_W.
- **DONE:** done=1 for one cycle, then IDLE.
- **kclr:**
  - In IDLE, kptr=KERNEL_BASE on the next edge.
  - If kclr and start are asserted together in mode 10, the burst starts from KERNEL_BASE.
  - Ignored outside IDLE.
- **start outside IDLE:** ignored, no err. Inputs are latched, so changes to base, pitch, ksize or mode mid-burst have no effect.
- **Wrap-around:** base+r*pitch+c beyond 2^ADDR_W-1 wraps silently.

## Timing
- Reset values:
  - state=IDLE, addr=0, addr_valid=0, last=0, busy=0, done=0, err=0
  - kptr=KERNEL_BASE, all counters 0
- Reset is asynchronous. It aborts any burst immediately. No done is issued for an aborted burst.
- All outputs are registered.
- Latency:
  - A start accepted at edge t gives addr_valid=1 and the first address at edge t+1.
  - busy=1 from edge t+1 until DONE is entered.
- Handshake:
  - A beat transfers on a posedge with addr_valid && ready.
  - While addr_valid && !ready, addr and last are held stable.
  - addr_valid never drops mid-burst.
- Throughput: with ready held at 1, one address per cycle.
- A K*K burst occupies K*K cycles of valid, then 1 DONE cycle. The next start is accepted in the cycle after DONE, i.e. while in IDLE.
- last is asserted together with the K*K-th address.
- done is asserted in the cycle after the last beat is accepted, with addr_valid=0.
- err is asserted in the cycle after the rejected start.

## Test plan
- Reset, then mode=01, base=100, pitch=32, ksize=3, ready=1:
  - addr sequence 100,101,102,132,133,134,164,165,166
  - last on 166; done one cycle later
- Same burst with ready toggling 1,0,0,1,…:
  - identical sequence
  - addr held stable during stalls
  - done only after 166 is accepted
- Two bursts with mode=10, ksize=2 (KERNEL_BASE=0), then kclr, then mode=10 with ksize=1:
  - bursts yield 0..3, then 4..7, then 0
  - each kernel burst asserts last on its final address
- mode=01, base=16380, pitch=1, ksize=2 (ADDR_W=14):
  - yields 16380,16381,16381,16382
  - wrap check: base=16383 yields 16383,0,0,1
- start with ksize=0, then ksize=KMAX+1, then mode=11:
  - err pulses three times
  - busy and addr_valid stay 0
- Assert rst mid-burst at beat 4 of 9:
  - all outputs return to reset values immediately
  - no done
  - the next start(mode=01) restarts at base

Source files
------------

// File: rtl/window_addr_gen.sv
// Address sequencer for convolution windows: emits a KxK row-major scope burst or a
// persistent, auto-advancing kernel-weight pointer burst under a valid/ready handshake.
module window_addr_gen #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned KSZ_W       = 3,
  parameter int unsigned KMAX        = 7,
  parameter int unsigned KERNEL_BASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] pitch,
  input  logic [KSZ_W-1:0]  ksize,
  input  logic              kclr,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [KSZ_W-1:0]  KMAX_K = KSZ_W'(KMAX);
  localparam logic [ADDR_W-1:0] KBASE  = ADDR_W'(KERNEL_BASE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCOPE = 2'd1,
    ST_KERN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_last, w_last_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_row_base, w_row_base_nxt;
  logic [ADDR_W-1:0] r_pitch, w_pitch_nxt;
  logic [ADDR_W-1:0] r_kptr, w_kptr_nxt;
  logic [KSZ_W-1:0]  r_k, w_k_nxt;
  logic [KSZ_W-1:0]  r_col, w_col_nxt;
  logic [KSZ_W-1:0]  r_row, w_row_nxt;

  logic              w_k_ok;
  logic              w_accept;
  logic [KSZ_W-1:0]  w_kmax1;

  assign w_k_ok   = (ksize != '0) && (ksize <= KMAX_K);
  assign w_accept = r_valid && ready;
  assign w_kmax1  = r_k - KSZ_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_row_base <= '0;
      r_pitch    <= '0;
      r_kptr     <= KBASE;
      r_k        <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_row_base <= w_row_base_nxt;
      r_pitch    <= w_pitch_nxt;
      r_kptr     <= w_kptr_nxt;
      r_k        <= w_k_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
    end
  end

  // Next-state and next-output logic; both burst types walk the same KxK row/col counters
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_valid_nxt    = r_valid;
    w_last_nxt     = r_last;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_row_base_nxt = r_row_base;
    w_pitch_nxt    = r_pitch;
    w_kptr_nxt     = r_kptr;
    w_k_nxt        = r_k;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;

    case (r_state)
      ST_IDLE: begin
        if (kclr) w_kptr_nxt = KBASE;
        if (start) begin
          if (mode == 2'b01 && w_k_ok) begin
            w_state_nxt    = ST_SCOPE;
            w_k_nxt        = ksize;
            w_pitch_nxt    = pitch;
            w_row_base_nxt = base;
            w_col_nxt      = '0;
            w_row_nxt      = '0;
            w_addr_nxt     = base;
            w_valid_nxt    = 1'b1;
            w_busy_nxt     = 1'b1;
            w_last_nxt     = (ksize == KSZ_W'(1));
          end else if (mode == 2'b10 && w_k_ok) begin
            w_state_nxt    = ST_KERN;
            w_k_nxt        = ksize;
            w_col_nxt      = '0;
            w_row_nxt      = '0;
            w_addr_nxt     = w_kptr_nxt;
            w_valid_nxt    = 1'b1;
            w_busy_nxt     = 1'b1;
            w_last_nxt     = (ksize == KSZ_W'(1));
          end else if (mode != 2'b00) begin
            w_err_nxt      = 1'b1;
          end
        end
      end

      ST_SCOPE, ST_KERN: begin
        if (w_accept) begin
          if (r_state == ST_KERN) w_kptr_nxt = r_kptr + ADDR_W'(1);
          if (r_last) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            if (r_col == w_kmax1) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + KSZ_W'(1);
            end else begin
              w_col_nxt = r_col + KSZ_W'(1);
            end
            // Scope rows advance by adding pitch to a running row base, never by multiplying
            if (r_state == ST_SCOPE && r_col == w_kmax1) begin
              w_row_base_nxt = r_row_base + r_pitch;
              w_addr_nxt     = r_row_base + r_pitch;
            end else begin
              w_addr_nxt     = r_addr + ADDR_W'(1);
            end
            w_last_nxt = (w_col_nxt == w_kmax1) && (w_row_nxt == w_kmax1);
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign addr       = r_addr;
  assign addr_valid = r_valid;
  assign last       = r_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench for window_addr_gen: queue-based burst model checked every cycle,
// plus literal address sequences from hand calculation.
module tb_window_addr_gen;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned KSZ_W  = 3;
  localparam int unsigned KMAX   = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] pitch;
  logic [KSZ_W-1:0]  ksize;
  logic              kclr;
  logic              ready = 1'b1;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              last;
  logic              busy;
  logic              done;
  logic              err;

  window_addr_gen #(
    .ADDR_W(ADDR_W), .KSZ_W(KSZ_W), .KMAX(KMAX), .KERNEL_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .pitch(pitch),
    .ksize(ksize), .kclr(kclr), .ready(ready), .addr(addr), .addr_valid(addr_valid),
    .last(last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  int ready_mode = 0;
  int pat_cnt = 0;
  logic [ADDR_W-1:0] acc[$];
  logic [ADDR_W-1:0] last_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request becomes a queue of the addresses it must produce
  logic [ADDR_W-1:0] m_q[$];
  logic [ADDR_W-1:0] m_kptr;
  bit m_burst, m_donecyc, m_done, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_burst = 0; m_donecyc = 0; m_done = 0; m_err = 0;
      m_kptr = '0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_burst) begin
        if (ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_burst = 0; m_done = 1; m_donecyc = 1;
          end
        end
      end else if (m_donecyc) begin
        m_donecyc = 0;
      end else begin
        if (kclr) m_kptr = '0;
        if (start && mode != 2'd0) begin
          if (mode != 2'd3 && ksize >= KSZ_W'(1) && 32'(ksize) <= KMAX) begin
            for (int unsigned r = 0; r < 32'(ksize); r++)
              for (int unsigned c = 0; c < 32'(ksize); c++) begin
                if (mode == 2'd1) begin
                  m_q.push_back(ADDR_W'(32'(base) + r * 32'(pitch) + c));
                end else begin
                  m_q.push_back(m_kptr);
                  m_kptr = m_kptr + ADDR_W'(1);
                end
              end
            m_burst = 1;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      check("addr_valid", 32'(addr_valid), 32'(m_burst));
      check("busy", 32'(busy), 32'(m_burst));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      if (m_burst) begin
        check("addr", 32'(addr), 32'(m_q[0]));
        check("last", 32'(last), 32'(m_q.size() == 1));
      end
      if (done) n_done++;
      if (err) n_err++;
    end
  end

  always @(posedge clk) begin
    if (rst && addr_valid && ready) begin
      acc.push_back(addr);
      if (last) last_seen = addr;
    end
  end

  always @(negedge clk) begin
    if (ready_mode == 1) begin
      ready = (pat_cnt % 3 == 0);
      pat_cnt++;
    end else begin
      ready = 1'b1;
    end
  end

  task automatic issue(input logic [1:0] m, input int b, input int p, input int k, input logic c);
    @(negedge clk);
    start = 1'b1; mode = m; base = ADDR_W'(b); pitch = ADDR_W'(p); ksize = KSZ_W'(k); kclr = c;
    @(negedge clk);
    start = 1'b0; mode = 2'd0; kclr = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!m_burst && !m_donecyc) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic check_seq(input string nm, input int exp[$]);
    check({nm, "_len"}, 32'(acc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc.size(); i++)
      check($sformatf("%s[%0d]", nm, i), 32'(acc[i]), 32'(exp[i]));
  endtask

  int scope_seq[$];
  int d0, e0;

  initial begin
    scope_seq = {100, 101, 102, 132, 133, 134, 164, 165, 166};
    rst = 1'b0; start = 1'b0; mode = 2'd0; base = '0; pitch = '0; ksize = '0; kclr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Plain scope burst
    acc.delete(); d0 = n_done;
    issue(2'd1, 100, 32, 3, 1'b0);
    wait_idle("scope", 40);
    check_seq("scope", scope_seq);
    check("scope_last_addr", 32'(last_seen), 32'd166);
    check("scope_done_cnt", 32'(n_done - d0), 32'd1);

    // Same burst with stalls; a mid-burst start must be ignored
    acc.delete(); d0 = n_done; e0 = n_err;
    pat_cnt = 0; ready_mode = 1;
    issue(2'd1, 100, 32, 3, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 2'd3; ksize = '0;
    @(negedge clk);
    start = 1'b0; mode = 2'd0;
    wait_idle("stall", 80);
    ready_mode = 0;
    check_seq("stall", scope_seq);
    check("stall_done_cnt", 32'(n_done - d0), 32'd1);
    check("stall_no_err", 32'(n_err - e0), 32'd0);

    // Kernel bursts: contiguous, then clear, then clear together with start
    acc.delete();
    issue(2'd2, 0, 0, 2, 1'b0);
    wait_idle("kern1", 20);
    check_seq("kern1", {0, 1, 2, 3});
    acc.delete();
    issue(2'd2, 0, 0, 2, 1'b0);
    wait_idle("kern2", 20);
    check_seq("kern2", {4, 5, 6, 7});
    @(negedge clk); kclr = 1'b1;
    @(negedge clk); kclr = 1'b0;
    acc.delete();
    issue(2'd2, 0, 0, 1, 1'b0);
    wait_idle("kern3", 20);
    check_seq("kern3", {0});
    check("kern3_last_addr", 32'(last_seen), 32'd0);
    acc.delete();
    issue(2'd2, 0, 0, 2, 1'b1);
    wait_idle("kern4", 20);
    check_seq("kern4", {0, 1, 2, 3});

    // Address wrap-around
    acc.delete();
    issue(2'd1, 16380, 1, 2, 1'b0);
    wait_idle("wrap1", 20);
    check_seq("wrap1", {16380, 16381, 16381, 16382});
    acc.delete();
    issue(2'd1, 16383, 1, 2, 1'b0);
    wait_idle("wrap2", 20);
    check_seq("wrap2", {16383, 0, 0, 1});

    // Rejected and ignored requests
    e0 = n_err;
    issue(2'd1, 0, 1, 0, 1'b0);
    issue(2'd1, 0, 1, KMAX + 1, 1'b0);
    issue(2'd3, 0, 1, 3, 1'b0);
    issue(2'd0, 0, 1, 3, 1'b0);
    repeat (2) @(negedge clk);
    check("err_pulses", 32'(n_err - e0), 32'd3);

    // Reset mid-burst, at beat 4 of 9
    acc.delete(); d0 = n_done;
    issue(2'd1, 100, 32, 3, 1'b0);
    for (int i = 0; i < 20 && acc.size() < 3; i++) @(negedge clk);
    check("abort_beat4_addr", 32'(addr), 32'd132);
    #2 rst = 1'b0;
    #1;
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_valid", 32'(addr_valid), 32'd0);
    check("abort_last", 32'(last), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    acc.delete();
    issue(2'd1, 100, 32, 3, 1'b0);
    wait_idle("restart", 40);
    check_seq("restart", scope_seq);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
